// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Brief    : Shared types and constants for the RV32I pipeline hazard controller.
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Encoding is fixed by the existing 3:1 operand mux in EX.
    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        D_WAIT = 2'b01,
        I_WAIT = 2'b10
    } hz_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // x0 is hardwired to zero, so it can never carry a dependency.
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != REG_X0) && (rd == rs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_sel_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_sel_unit
//  Brief    : Forwarding select for one ALU operand; EX/MEM beats MEM/WB.
//  Revision : 1.0 - initial release
// ============================================================================
module fwd_sel_unit
    import hazard_pkg::*;
(
    input  logic [4:0] i_ex_rs,
    input  logic [4:0] i_mem_rd,
    input  logic       i_mem_reg_write,
    input  logic [4:0] i_wb_rd,
    input  logic       i_wb_reg_write,
    output logic [1:0] o_sel
);

    fwd_sel_t w_sel;

    always_comb begin
        w_sel = FWD_RF;
        if (i_mem_reg_write && reg_match(i_mem_rd, i_ex_rs)) begin
            w_sel = FWD_EXMEM;
        end else if (i_wb_reg_write && reg_match(i_wb_rd, i_ex_rs)) begin
            w_sel = FWD_MEMWB;
        end
    end

    assign o_sel = w_sel;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Brief    : Forwarding, load-use stall, branch flush and memory-wait freeze
//             control for the 5-stage RV32I pipeline, with perf counters.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic             mem_access,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] freeze_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int               c_to_w    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_to_w-1:0] c_to_max = c_to_w'(TIMEOUT);
    localparam logic [CNT_W-1:0]  c_cnt_max = '1;

    logic              w_dwait;
    logic              w_iwait;
    logic              w_freeze;
    logic              w_branch;
    logic              w_lu_hit;
    logic              w_load_use;
    logic [c_to_w-1:0] w_to_nxt;

    hz_state_t         r_state;
    hz_state_t         w_state_nxt;
    logic [c_to_w-1:0] r_to_cnt;
    logic              r_mem_timeout;
    logic [CNT_W-1:0]  r_lu_cnt;
    logic [CNT_W-1:0]  r_freeze_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    fwd_sel_unit u_fwd_a (
        .i_ex_rs         (ex_rs1),
        .i_mem_rd        (mem_rd),
        .i_mem_reg_write (mem_reg_write),
        .i_wb_rd         (wb_rd),
        .i_wb_reg_write  (wb_reg_write),
        .o_sel           (fwd_a_sel)
    );

    fwd_sel_unit u_fwd_b (
        .i_ex_rs         (ex_rs2),
        .i_mem_rd        (mem_rd),
        .i_mem_reg_write (mem_reg_write),
        .i_wb_rd         (wb_rd),
        .i_wb_reg_write  (wb_reg_write),
        .o_sel           (fwd_b_sel)
    );

    assign w_dwait  = mem_access & ~dmem_ready;
    assign w_iwait  = ~imem_ready;
    assign w_freeze = w_dwait | w_iwait;

    assign w_lu_hit = ex_mem_read && (ex_rd != REG_X0) &&
                      ((id_use_rs1 && (ex_rd == id_rs1)) ||
                       (id_use_rs2 && (ex_rd == id_rs2)));

    // A freeze masks everything; a taken branch makes the load-use stall moot.
    assign w_branch   = ~w_freeze & ex_branch_taken;
    assign w_load_use = ~w_freeze & ~ex_branch_taken & w_lu_hit;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (w_freeze) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (w_branch) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (w_load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    assign pipe_freeze = w_freeze;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (w_dwait) begin
                    w_state_nxt = D_WAIT;
                end else if (w_iwait) begin
                    w_state_nxt = I_WAIT;
                end
            end
            D_WAIT: begin
                if (w_dwait) begin
                    w_state_nxt = D_WAIT;
                end else if (w_iwait) begin
                    w_state_nxt = I_WAIT;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            I_WAIT: begin
                if (w_dwait) begin
                    w_state_nxt = D_WAIT;
                end else if (w_iwait) begin
                    w_state_nxt = I_WAIT;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Run-length counter holds at TIMEOUT so a long stall cannot wrap it.
    assign w_to_nxt = (r_to_cnt == c_to_max) ? c_to_max : r_to_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt      <= '0;
            r_mem_timeout <= 1'b0;
        end else if (w_freeze) begin
            r_to_cnt <= w_to_nxt;
            if (w_to_nxt == c_to_max) begin
                r_mem_timeout <= 1'b1;
            end
        end else begin
            r_to_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lu_cnt     <= '0;
            r_freeze_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_load_use && (r_lu_cnt != c_cnt_max)) begin
                r_lu_cnt <= r_lu_cnt + 1'b1;
            end
            if (w_freeze && (r_freeze_cnt != c_cnt_max)) begin
                r_freeze_cnt <= r_freeze_cnt + 1'b1;
            end
            if (w_branch && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign mem_timeout  = r_mem_timeout;
    assign lu_stall_cnt = r_lu_cnt;
    assign freeze_cnt   = r_freeze_cnt;
    assign flush_cnt    = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Brief    : Self-checking bench for hazard_ctrl (vector table, directed
//             multi-cycle sequences and random stimulus vs. reference model).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int TO   = 4;
    localparam int CW   = 16;
    localparam int CW_S = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
    logic mem_reg_write, mem_access, wb_reg_write, imem_ready, dmem_ready;

    logic [1:0] fwd_a_sel, fwd_b_sel, fwd_a_sel_s, fwd_b_sel_s;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_timeout;
    logic pc_write_s, ifid_write_s, ifid_flush_s, idex_bubble_s, pipe_freeze_s, mem_timeout_s;
    logic [CW-1:0]   lu_stall_cnt, freeze_cnt, flush_cnt;
    logic [CW_S-1:0] lu_stall_cnt_s, freeze_cnt_s, flush_cnt_s;

    hazard_ctrl #(.CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_access(mem_access), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .pc_write(pc_write),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout),
        .lu_stall_cnt(lu_stall_cnt), .freeze_cnt(freeze_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    hazard_ctrl #(.CNT_W(CW_S), .TIMEOUT(TO)) dut_s (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_access(mem_access), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .fwd_a_sel(fwd_a_sel_s), .fwd_b_sel(fwd_b_sel_s), .pc_write(pc_write_s),
        .ifid_write(ifid_write_s), .ifid_flush(ifid_flush_s), .idex_bubble(idex_bubble_s),
        .pipe_freeze(pipe_freeze_s), .mem_timeout(mem_timeout_s),
        .lu_stall_cnt(lu_stall_cnt_s), .freeze_cnt(freeze_cnt_s), .flush_cnt(flush_cnt_s)
    );

    typedef struct {
        logic [4:0] id_rs1, id_rs2;
        logic       id_use_rs1, id_use_rs2;
        logic [4:0] ex_rs1, ex_rs2, ex_rd;
        logic       ex_mem_read, ex_branch_taken;
        logic [4:0] mem_rd;
        logic       mem_reg_write, mem_access;
        logic [4:0] wb_rd;
        logic       wb_reg_write, imem_ready, dmem_ready;
    } in_t;

    typedef struct {
        in_t        in;
        logic [1:0] fa, fb;
        logic       pc, ifw, fl, bub, frz;
    } vec_t;

    vec_t tbl[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: run length of frozen cycles and raw event counts.
    hz_state_t m_state;
    int        m_run, m_lu, m_fr, m_fl;
    logic      m_timeout;
    logic [1:0] e_fa, e_fb;
    logic       e_pc, e_ifw, e_fl, e_bub, e_frz, e_lu, e_br;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t v;
        v = '{default: '0};
        v.imem_ready = 1'b1;
        return v;
    endfunction

    function automatic in_t rnd();
        in_t v;
        v.id_rs1          = 5'($urandom_range(0, 3));
        v.id_rs2          = 5'($urandom_range(0, 3));
        v.id_use_rs1      = 1'($urandom_range(0, 1));
        v.id_use_rs2      = 1'($urandom_range(0, 1));
        v.ex_rs1          = 5'($urandom_range(0, 3));
        v.ex_rs2          = 5'($urandom_range(0, 3));
        v.ex_rd           = 5'($urandom_range(0, 3));
        v.ex_mem_read     = ($urandom_range(0, 2) == 0);
        v.ex_branch_taken = ($urandom_range(0, 3) == 0);
        v.mem_rd          = 5'($urandom_range(0, 3));
        v.mem_reg_write   = 1'($urandom_range(0, 1));
        v.mem_access      = 1'($urandom_range(0, 1));
        v.wb_rd           = 5'($urandom_range(0, 3));
        v.wb_reg_write    = 1'($urandom_range(0, 1));
        v.imem_ready      = ($urandom_range(0, 7) != 0);
        v.dmem_ready      = ($urandom_range(0, 2) != 0);
        return v;
    endfunction

    task automatic drive(input in_t v);
        id_rs1 = v.id_rs1; id_rs2 = v.id_rs2;
        id_use_rs1 = v.id_use_rs1; id_use_rs2 = v.id_use_rs2;
        ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2; ex_rd = v.ex_rd;
        ex_mem_read = v.ex_mem_read; ex_branch_taken = v.ex_branch_taken;
        mem_rd = v.mem_rd; mem_reg_write = v.mem_reg_write; mem_access = v.mem_access;
        wb_rd = v.wb_rd; wb_reg_write = v.wb_reg_write;
        imem_ready = v.imem_ready; dmem_ready = v.dmem_ready;
    endtask

    task automatic add(input in_t v, input logic [1:0] fa, input logic [1:0] fb,
                       input logic pc, input logic ifw, input logic fl,
                       input logic bub, input logic frz);
        vec_t r;
        r.in = v; r.fa = fa; r.fb = fb;
        r.pc = pc; r.ifw = ifw; r.fl = fl; r.bub = bub; r.frz = frz;
        tbl.push_back(r);
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b01;
        if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int sat(input int n, input int w);
        int m;
        m = (1 << w) - 1;
        return (n > m) ? m : n;
    endfunction

    task automatic model_reset();
        m_state = RUN; m_run = 0; m_timeout = 1'b0;
        m_lu = 0; m_fr = 0; m_fl = 0;
    endtask

    task automatic model_comb();
        logic dw, iw, hit;
        dw    = mem_access && !dmem_ready;
        iw    = !imem_ready;
        e_frz = dw || iw;
        hit   = ex_mem_read && ex_rd != 0 &&
                ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
        e_br  = !e_frz && ex_branch_taken;
        e_lu  = !e_frz && !ex_branch_taken && hit;
        e_fa  = ref_fwd(ex_rs1);
        e_fb  = ref_fwd(ex_rs2);
        e_pc  = !e_frz && !e_lu;
        e_ifw = !e_frz && !e_lu;
        e_fl  = e_br;
        e_bub = e_br || e_lu;
    endtask

    task automatic check_model();
        model_comb();
        chk("fwd_a_sel", 32'(fwd_a_sel), 32'(e_fa));
        chk("fwd_b_sel", 32'(fwd_b_sel), 32'(e_fb));
        chk("pc_write", 32'(pc_write), 32'(e_pc));
        chk("ifid_write", 32'(ifid_write), 32'(e_ifw));
        chk("ifid_flush", 32'(ifid_flush), 32'(e_fl));
        chk("idex_bubble", 32'(idex_bubble), 32'(e_bub));
        chk("pipe_freeze", 32'(pipe_freeze), 32'(e_frz));
        chk("mem_timeout", 32'(mem_timeout), 32'(m_timeout));
        chk("state", 32'(dut.r_state), 32'(m_state));
        chk("lu_stall_cnt", 32'(lu_stall_cnt), sat(m_lu, CW));
        chk("freeze_cnt", 32'(freeze_cnt), sat(m_fr, CW));
        chk("flush_cnt", 32'(flush_cnt), sat(m_fl, CW));
        chk("lu_stall_cnt_s", 32'(lu_stall_cnt_s), sat(m_lu, CW_S));
        chk("freeze_cnt_s", 32'(freeze_cnt_s), sat(m_fr, CW_S));
        chk("flush_cnt_s", 32'(flush_cnt_s), sat(m_fl, CW_S));
    endtask

    // Sample at the falling edge, away from the active edge.
    task automatic sample();
        @(negedge clk);
        check_model();
    endtask

    task automatic step_clk();
        logic dw, iw;
        model_comb();
        dw = mem_access && !dmem_ready;
        iw = !imem_ready;
        m_state = dw ? D_WAIT : (iw ? I_WAIT : RUN);
        m_run   = e_frz ? m_run + 1 : 0;
        if (m_run >= TO) m_timeout = 1'b1;
        if (e_frz) m_fr++;
        if (e_lu)  m_lu++;
        if (e_br)  m_fl++;
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        drive(idle());
        #2;
        rst = 1'b0;
        #1;
        chk("arst_mem_timeout", 32'(mem_timeout), 32'd0);
        chk("arst_freeze_cnt", 32'(freeze_cnt), 32'd0);
        chk("arst_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("arst_state", 32'(dut.r_state), 32'(RUN));
        model_reset();
        sample();
        rst = 1'b1;
        step_clk();
    endtask

    initial begin
        in_t v;
        drive(idle());
        model_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
        chk("rst_fwd_b", 32'(fwd_b_sel), 32'd0);
        chk("rst_pc_write", 32'(pc_write), 32'd1);
        chk("rst_ifid_write", 32'(ifid_write), 32'd1);
        chk("rst_bubble", 32'(idex_bubble), 32'd0);
        chk("rst_mem_timeout", 32'(mem_timeout), 32'd0);
        chk("rst_lu_cnt", 32'(lu_stall_cnt), 32'd0);
        sample();
        rst = 1'b1;
        step_clk();

        // ---------------- vector table ----------------
        v = idle();                                                      add(v, 2'b00, 2'b00, 1, 1, 0, 0, 0);
        v = idle(); v.mem_rd = 5; v.mem_reg_write = 1; v.wb_rd = 5;
        v.wb_reg_write = 1; v.ex_rs1 = 5;                                add(v, 2'b01, 2'b00, 1, 1, 0, 0, 0);
        v.mem_reg_write = 0;                                             add(v, 2'b10, 2'b00, 1, 1, 0, 0, 0);
        v.mem_reg_write = 1; v.mem_rd = 0; v.wb_rd = 0; v.ex_rs1 = 0;    add(v, 2'b00, 2'b00, 1, 1, 0, 0, 0);
        v = idle(); v.mem_rd = 9; v.mem_reg_write = 1; v.wb_rd = 12;
        v.wb_reg_write = 1; v.ex_rs1 = 12; v.ex_rs2 = 9;                 add(v, 2'b10, 2'b01, 1, 1, 0, 0, 0);
        v = idle(); v.ex_mem_read = 1; v.ex_rd = 7; v.id_rs2 = 7;
        v.id_use_rs2 = 1;                                                add(v, 2'b00, 2'b00, 0, 0, 0, 1, 0);
        v.id_use_rs2 = 0;                                                add(v, 2'b00, 2'b00, 1, 1, 0, 0, 0);
        v = idle(); v.ex_mem_read = 1; v.ex_rd = 3; v.id_rs1 = 3;
        v.id_use_rs1 = 1;                                                add(v, 2'b00, 2'b00, 0, 0, 0, 1, 0);
        v.ex_rd = 0; v.id_rs1 = 0;                                       add(v, 2'b00, 2'b00, 1, 1, 0, 0, 0);
        v = idle(); v.ex_mem_read = 1; v.ex_rd = 7; v.id_rs2 = 7;
        v.id_use_rs2 = 1; v.ex_branch_taken = 1;                         add(v, 2'b00, 2'b00, 1, 1, 1, 1, 0);
        v = idle(); v.ex_branch_taken = 1; v.imem_ready = 0;             add(v, 2'b00, 2'b00, 0, 0, 0, 0, 1);
        v = idle();                                                      add(v, 2'b00, 2'b00, 1, 1, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].in);
            sample();
            chk($sformatf("tbl%0d_fwd_a", i), 32'(fwd_a_sel), 32'(tbl[i].fa));
            chk($sformatf("tbl%0d_fwd_b", i), 32'(fwd_b_sel), 32'(tbl[i].fb));
            chk($sformatf("tbl%0d_pc_write", i), 32'(pc_write), 32'(tbl[i].pc));
            chk($sformatf("tbl%0d_ifid_write", i), 32'(ifid_write), 32'(tbl[i].ifw));
            chk($sformatf("tbl%0d_ifid_flush", i), 32'(ifid_flush), 32'(tbl[i].fl));
            chk($sformatf("tbl%0d_idex_bubble", i), 32'(idex_bubble), 32'(tbl[i].bub));
            chk($sformatf("tbl%0d_pipe_freeze", i), 32'(pipe_freeze), 32'(tbl[i].frz));
            step_clk();
        end
        chk("tbl_lu_stall_cnt", 32'(lu_stall_cnt), 32'd2);
        chk("tbl_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("tbl_freeze_cnt", 32'(freeze_cnt), 32'd1);

        // ---------------- DM wait with a pending taken branch ----------------
        v = idle(); v.mem_access = 1; v.dmem_ready = 0; v.ex_branch_taken = 1;
        drive(v);
        for (int k = 1; k <= 3; k++) begin
            sample();
            chk($sformatf("dm%0d_freeze", k), 32'(pipe_freeze), 32'd1);
            chk($sformatf("dm%0d_no_flush", k), 32'(ifid_flush), 32'd0);
            step_clk();
            chk($sformatf("dm%0d_state", k), 32'(dut.r_state), 32'(D_WAIT));
        end
        chk("dm_freeze_cnt", 32'(freeze_cnt), 32'd4);
        chk("dm_no_timeout", 32'(mem_timeout), 32'd0);
        v.dmem_ready = 1;
        drive(v);
        sample();
        chk("dm4_flush", 32'(ifid_flush), 32'd1);
        chk("dm4_pc_write", 32'(pc_write), 32'd1);
        step_clk();
        chk("dm4_state", 32'(dut.r_state), 32'(RUN));
        chk("dm4_flush_cnt", 32'(flush_cnt), 32'd2);
        drive(idle());
        sample();
        step_clk();

        // ---------------- IM wait timeout ----------------
        v = idle(); v.imem_ready = 0;
        drive(v);
        for (int k = 1; k <= 6; k++) begin
            sample();
            step_clk();
            chk($sformatf("to%0d_mem_timeout", k), 32'(mem_timeout), (k >= TO) ? 32'd1 : 32'd0);
            chk($sformatf("to%0d_state", k), 32'(dut.r_state), 32'(I_WAIT));
        end
        drive(idle());
        sample();
        step_clk();
        chk("to_sticky", 32'(mem_timeout), 32'd1);
        chk("to_state_run", 32'(dut.r_state), 32'(RUN));
        async_reset();

        // ---------------- counter saturation (narrow instance) ----------------
        v = idle(); v.ex_branch_taken = 1;
        drive(v);
        for (int k = 0; k < 5; k++) begin
            sample();
            step_clk();
        end
        chk("sat_flush_cnt_s", 32'(flush_cnt_s), 32'd3);
        chk("sat_flush_cnt", 32'(flush_cnt), 32'd5);

        // ---------------- random traffic vs. model ----------------
        for (int k = 0; k < 600; k++) begin
            drive(rnd());
            sample();
            step_clk();
            if (k == 300) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
